// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional code.
// Generators and packing live here so the encoder and its decoder agree.
`timescale 1ns/1ps
package conv_pkg;

    localparam int          MAX_BITS = 7;
    localparam int          EST_W    = 2 * MAX_BITS;
    localparam int          SIZE_W   = $clog2(MAX_BITS + 1);
    localparam logic [2:0]  G0       = 3'b111;
    localparam logic [2:0]  G1       = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // {c0, c1}
    typedef logic [1:0] pair_t;

endpackage

// File: rtl/conv_enc_core.sv
// One trellis step: code pair and next shift state for input bit u.
`timescale 1ns/1ps
module conv_enc_core
    import conv_pkg::*;
(
    input  logic  u,
    input  logic  s0,
    input  logic  s1,
    output pair_t pair,
    output logic  s0_next,
    output logic  s1_next
);

    logic [2:0] taps;

    assign taps    = {u, s0, s1};
    assign pair    = {^(G0 & taps), ^(G1 & taps)};
    assign s0_next = u;
    assign s1_next = s0;

endmodule

// File: rtl/conv_encoder.sv
// Convolutional encoder: one data bit per clock, MSB of the used field first,
// pairs packed MSB-first into estring in the layout the decoder consumes.
`timescale 1ns/1ps
module conv_encoder
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MAX_BITS-1:0] dstring,
    input  logic [SIZE_W-1:0]   size,
    output logic [EST_W-1:0]    estring,
    output pair_t               code_pair,
    output logic                code_valid,
    output logic                busy,
    output logic                done
);

    // Handshake: start is sampled on a rising edge and accepted only when the
    // FSM is in IDLE or DONE; dstring/size are captured on that same edge.
    // done is a one-cycle pulse; estring is stable from done until the next
    // accepted start. code_valid marks each cycle holding a fresh code_pair.

    state_t              state, state_next;
    logic [MAX_BITS-1:0] data_q;
    logic [SIZE_W-1:0]   cnt;
    logic                s0, s1;
    logic                accept;
    logic                u;
    pair_t               pair;
    logic                s0_next, s1_next;
    logic [3:0]          pos;

    assign accept = start && (state != ENCODE);
    assign u      = data_q[cnt - 3'd1];
    assign pos    = {cnt - 3'd1, 1'b0};
    assign busy   = (state == ENCODE);
    assign done   = (state == DONE);

    conv_enc_core u_core (
        .u       (u),
        .s0      (s0),
        .s1      (s1),
        .pair    (pair),
        .s0_next (s0_next),
        .s1_next (s1_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_next = (size == '0) ? DONE : ENCODE;
                else        state_next = IDLE;
            end
            ENCODE: begin
                if (cnt == 3'd1) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            cnt        <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            estring    <= '0;
            code_pair  <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (accept) begin
                data_q  <= dstring;
                cnt     <= size;
                estring <= '0;
                s0      <= 1'b0;
                s1      <= 1'b0;
            end else if (state == ENCODE) begin
                // Pair for the bit at position cnt-1 lands at estring[2*(cnt-1) +: 2].
                estring[pos +: 2] <= pair;
                code_pair         <= pair;
                code_valid        <= 1'b1;
                cnt               <= cnt - 3'd1;
                s0                <= s0_next;
                s1                <= s1_next;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: table vectors, corner sequences and random
// messages checked against a bit-serial reference model and a re-decode.
`timescale 1ns/1ps
module tb_conv_encoder;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  dstring;
    logic [2:0]  size;
    logic [13:0] estring;
    pair_t       code_pair;
    logic        code_valid;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_q[$];
    bit          sb_on = 1'b1;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    typedef struct {
        logic [6:0]  d;
        logic [2:0]  sz;
        logic [13:0] e;
    } vec_t;

    vec_t vecs[6];

    // ---------------- clock / dut ----------------
    always #5 clk = ~clk;

    conv_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dstring    (dstring),
        .size       (size),
        .estring    (estring),
        .code_pair  (code_pair),
        .code_valid (code_valid),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] enc_pair(int u, int s0, int s1);
        logic [2:0] taps;
        int c0, c1;
        taps = 3'(u * 4 + s0 * 2 + s1);
        c0 = $countones(G0 & taps) % 2;
        c1 = $countones(G1 & taps) % 2;
        return 2'(c0 * 2 + c1);
    endfunction

    function automatic logic [13:0] model_enc(logic [6:0] d, int sz);
        logic [13:0] e;
        int s0, s1, u;
        e = '0; s0 = 0; s1 = 0;
        for (int k = 1; k <= sz; k++) begin
            u = int'(d[sz - k]);
            e[2 * (sz - k) +: 2] = enc_pair(u, s0, s1);
            s1 = s0;
            s0 = u;
        end
        return e;
    endfunction

    // Noise-free decode: the branch taken is the one whose pair matches.
    function automatic logic [6:0] decode(logic [13:0] e, int sz);
        logic [6:0] r;
        logic [1:0] p;
        int s0, s1, u;
        r = '0; s0 = 0; s1 = 0;
        for (int k = 1; k <= sz; k++) begin
            p = e[2 * (sz - k) +: 2];
            u = (p == enc_pair(0, s0, s1)) ? 0 : 1;
            r[sz - k] = 1'(u);
            s1 = s0;
            s0 = u;
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pairs(logic [13:0] e, int sz);
        for (int k = 1; k <= sz; k++) exp_q.push_back(e[2 * (sz - k) +: 2]);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (code_valid && sb_on) begin
                if (exp_q.size() == 0) check("pair_unexpected", 32'(code_valid), 32'd0);
                else check("code_pair", 32'(code_pair), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_msg(logic [6:0] d, int sz, logic [13:0] exp_e);
        int n, b0, d0;
        logic [6:0] mask;
        mask = 7'((1 << sz) - 1);
        push_pairs(exp_e, sz);
        @(negedge clk);
        b0 = busy_cnt; d0 = done_cnt;
        dstring = d; size = 3'(sz); start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start   = 1'b0;
                dstring = 7'($urandom);
                size    = 3'($urandom);
            end
        end while (!done && n < 20);
        check("done_timeout", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(sz + 1));
        check("estring", 32'(estring), 32'(exp_e));
        check("loopback", 32'(decode(estring, sz)), 32'(d & mask));
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("estring_hold", 32'(estring), 32'(exp_e));
        check("busy_cycles", 32'(busy_cnt - b0), 32'(sz));
        check("done_cycles", 32'(done_cnt - d0), 32'd1);
        check("pairs_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 20);
        check(name, 32'(done), 32'd1);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [6:0]  rd;
        int          rs;
        int          d0;

        vecs[0] = '{7'b0000101, 3'd3, 14'b00000000111000};
        vecs[1] = '{7'b1000000, 3'd7, 14'b11101100000000};
        vecs[2] = '{7'b1010101, 3'd0, 14'b00000000000000};
        vecs[3] = '{7'b0000001, 3'd1, 14'b00000000000011};
        vecs[4] = '{7'b1111111, 3'd7, 14'b11011010101010};
        vecs[5] = '{7'b1111111, 3'd2, 14'b00000000001101};

        rst = 1'b1; start = 1'b0; dstring = '0; size = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_estring", 32'(estring), 32'd0);
        check("rst_code_valid", 32'(code_valid), 32'd0);
        check("rst_code_pair", 32'(code_pair), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_msg(vecs[i].d, int'(vecs[i].sz), vecs[i].e);

        // start held high: second message launched from DONE, shift state re-zeroed
        @(negedge clk);
        push_pairs(14'b11, 1);
        push_pairs(14'b11, 1);
        dstring = 7'b0000001; size = 3'd1; start = 1'b1;
        wait_done("hold_done1");
        check("hold_estring1", 32'(estring), 32'h3);
        @(posedge clk); #1;
        check("hold_busy2", 32'(busy), 32'd1);
        check("hold_done_gap", 32'(done), 32'd0);
        wait_done("hold_done2");
        check("hold_estring2", 32'(estring), 32'h3);
        start = 1'b0;
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        check("hold_pairs_left", 32'(exp_q.size()), 32'd0);

        // reset mid-ENCODE
        sb_on = 1'b0;
        @(negedge clk);
        dstring = 7'($urandom); size = 3'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_estring", 32'(estring), 32'd0);
        check("mid_rst_code_valid", 32'(code_valid), 32'd0);
        check("mid_rst_code_pair", 32'(code_pair), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        sb_on = 1'b1;
        rd = 7'($urandom);
        run_msg(rd, 7, model_enc(rd, 7));

        // random messages
        for (int i = 0; i < 40; i++) begin
            rd = 7'($urandom);
            rs = int'($urandom_range(0, 7));
            run_msg(rd, rs, model_enc(rd, rs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the existing `decoder` block.
- It takes a data word of up to 7 bits plus a size field. It produces the 14-bit coded string in the exact packing that `decoder` consumes on `rstring`.
- It encodes one data bit per clock and streams each code pair as it is produced. It holds the assembled string until the next start and pulses `done` when finished.

Parameters:
- MAX_BITS, 7, maximum data bits per message. `dstring` is MAX_BITS wide; `estring` is 2*MAX_BITS wide.
- G0, 3'b111, generator for the upper code bit c0, ordered {u, s0, s1}.
- G1, 3'b101, generator for the lower code bit c1, ordered {u, s0, s1}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to encode. Sampled on a clock edge; honoured only in IDLE or DONE.
- dstring  in  7  data word. Bits [size-1:0] are used; bit size-1 is encoded first.
- size  in  3  number of data bits, 0..7. Latched at start.
- estring  out  14  coded string. Pairs are packed MSB-first into [2*size-1:0]; unused upper bits are 0.
- code_pair  out  2  most recent pair, {c0,c1}.
- code_valid  out  1  high for one cycle per newly produced pair.
- busy  out  1  high while in ENCODE.
- done  out  1  one-cycle pulse when estring is complete.

Behaviour:
- Reset (async, immediate, from any state, including mid-message):
  - state goes to IDLE.
  - estring, code_pair, code_valid, busy and done all go to 0.
  - shift state {s0,s1} goes to 00 and the bit counter goes to 0.
- Encoder math, per bit u with shift state (s0 = previous bit, s1 = bit before):
  - c0 = ^(G0 & {u,s0,s1}).
  - c1 = ^(G1 & {u,s0,s1}).
  - Next state is s1<=s0, s0<=u.
  - Shift state is zeroed at every accepted start. There are no tail/flush bits (truncated code).
- Packing: the pair for the k-th processed bit (k = 1..size) is written to estring[2*(size-k)+1 : 2*(size-k)], with c0 in the upper bit.
- FSM states: IDLE, ENCODE, DONE.
- IDLE:
  - On a start edge: latch dstring and size, clear estring, clear shift state, and load counter = size.
  - Go to ENCODE if size != 0, else go to DONE.
- ENCODE (busy=1):
  - Each edge encodes bit dstring_latched[counter-1], writes its pair into estring and code_pair, sets code_valid=1, and decrements counter.
  - The edge that encodes the last bit (counter == 1) moves the FSM to DONE.
- DONE (done=1, busy=0):
  - Lasts one cycle. The final pair's code_valid is high in this same cycle.
  - estring is complete and stays stable until the next accepted start.
  - Next edge goes to IDLE. If start is high on that edge, it is accepted exactly as in IDLE (back-to-back messages).
- Latency: done is high in the cycle following edge size+1 after the start-sampling edge (size=0 gives done one edge after start).
- Start in ENCODE: ignored; the current message completes unchanged.
- Changes to dstring or size after start: no effect, because both are latched.
- code_valid is 0 in IDLE and in any cycle without a new pair. code_pair holds its last value.

Decomposition:
- Package conv_pkg holds:
  - MAX_BITS, G0 and G1.
  - the state enum type {IDLE, ENCODE, DONE}.
  - the typedef for the 2-bit pair.
  - This package is shared with `decoder` so the generators and packing cannot diverge.
- One sub-module, conv_enc_core: combinational. It takes (u, s0, s1) and outputs ({c0,c1}, next s0, next s1).
- conv_encoder owns the FSM, the counter, the latches and the packing.

Test Plan:
- Reset mid-ENCODE: start with size=7, then assert rst after 3 edges → all outputs immediately 0. state is IDLE and no done is emitted. A new start after reset encodes correctly.
- dstring=7'b0000101, size=3 → pairs 11, 10, 00 on three consecutive code_valid cycles. estring=14'b00000000111000, and done pulses on the third code_valid cycle.
- dstring=7'b1000000, size=7 → estring=14'b11101100000000. busy is high for 7 cycles and done is high for exactly 1.
- size=0 with start → done one edge later, estring=0 and no code_valid.
- Start held high continuously with size=1 and dstring=1:
  - The first message completes with estring=14'b11.
  - A start that is high during ENCODE is ignored.
  - The start sampled in DONE launches the second message immediately, and it produces 11 again because shift state is re-zeroed.
- Loopback: feed estring and size into `decoder` for random dstring and size → dstring is recovered exactly and both done signals assert.
